dmem_arbiter: RTL

- Two-port access controller placed in front of the single-port, word-addressed data memory: combinational read, write on clock edge.
- Arbitrates round-robin between requester A (core load/store unit) and requester B (debug/DMA).
- Converts byte addresses to word indices and performs byte/halfword loads with sign or zero extension.
- Implements sub-word stores as a sequenced read-modify-write, because the memory supports whole-word writes only.

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for a single-port word memory: byte/half loads with extension,
// sub-word stores sequenced as read-modify-write.
module dmem_arbiter #(
  parameter int unsigned dep = 64,
  parameter int unsigned wid = 32
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           a_valid,
  output logic           a_ready,
  input  logic           a_we,
  input  logic [1:0]     a_size,
  input  logic           a_unsigned,
  input  logic [wid-1:0] a_addr,
  input  logic [wid-1:0] a_wdata,

  input  logic           b_valid,
  output logic           b_ready,
  input  logic           b_we,
  input  logic [1:0]     b_size,
  input  logic           b_unsigned,
  input  logic [wid-1:0] b_addr,
  input  logic [wid-1:0] b_wdata,

  output logic           resp_valid_a,
  output logic           resp_valid_b,
  output logic [wid-1:0] resp_rdata,
  output logic           resp_err,

  output logic [wid-1:0] mem_address,
  output logic [wid-1:0] mem_wd,
  output logic           mem_we,
  input  logic [wid-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e         state_q;
  logic           prio_b_q;   // 1: B wins the next tie
  logic           sel_b_q;
  logic           we_q;
  logic           uns_q;
  logic [1:0]     size_q;
  logic [1:0]     lane_q;
  logic [wid-1:0] idx_q;
  logic [wid-1:0] wdata_q;
  logic [wid-1:0] merge_q;
  logic           resp_valid_a_q;
  logic           resp_valid_b_q;
  logic [wid-1:0] resp_rdata_q;
  logic           resp_err_q;

  logic           grant_a;
  logic           grant_b;
  logic           req_we;
  logic           req_uns;
  logic [1:0]     req_size;
  logic [wid-1:0] req_addr;
  logic [wid-1:0] req_wdata;
  logic [wid-1:0] req_idx;
  logic           req_err;
  logic           align_err;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [wid-1:0] load_val;
  logic [wid-1:0] merged;
  logic           word_store;

  always_comb begin
    grant_a = (state_q == StIdle) && !rst && a_valid && (!b_valid || !prio_b_q);
    grant_b = (state_q == StIdle) && !rst && b_valid && (!a_valid || prio_b_q);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    req_we    = grant_b ? b_we       : a_we;
    req_uns   = grant_b ? b_unsigned : a_unsigned;
    req_size  = grant_b ? b_size     : a_size;
    req_addr  = grant_b ? b_addr     : a_addr;
    req_wdata = grant_b ? b_wdata    : a_wdata;
    req_idx   = req_addr >> 2;
  end

  always_comb begin
    align_err = 1'b0;
    unique case (req_size)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = req_addr[0];
      2'd2:    align_err = (req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    req_err = align_err || (req_idx >= wid'(dep));
  end

  // Lane select and extension for loads, lane replacement for sub-word stores.
  always_comb begin
    ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    unique case (size_q)
      2'd0: load_val = uns_q ? {{(wid-8){1'b0}}, ld_byte} : {{(wid-8){ld_byte[7]}}, ld_byte};
      2'd1: load_val = uns_q ? {{(wid-16){1'b0}}, ld_half} : {{(wid-16){ld_half[15]}}, ld_half};
      default: load_val = mem_rdata;
    endcase

    merged = merge_q;
    unique case (size_q)
      2'd0:    merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign word_store = we_q && (size_q == 2'd2);

  // Write enable is combinational so that reset can kill a write in the same cycle.
  always_comb begin
    mem_we = 1'b0;
    mem_wd = '0;
    if (state_q == StAccess && word_store) begin
      mem_we = !rst;
      mem_wd = wdata_q;
    end else if (state_q == StWrite) begin
      mem_we = !rst;
      mem_wd = merged;
    end
  end

  assign mem_address  = idx_q;
  assign resp_valid_a = resp_valid_a_q;
  assign resp_valid_b = resp_valid_b_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      prio_b_q       <= 1'b0;
      sel_b_q        <= 1'b0;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'd0;
      lane_q         <= 2'd0;
      idx_q          <= '0;
      wdata_q        <= '0;
      merge_q        <= '0;
      resp_valid_a_q <= 1'b0;
      resp_valid_b_q <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      resp_valid_a_q <= 1'b0;
      resp_valid_b_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_a || grant_b) begin
            prio_b_q <= grant_a;
            sel_b_q  <= grant_b;
            we_q     <= req_we;
            uns_q    <= req_uns;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            idx_q    <= req_idx;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q        <= StResp;
              resp_valid_a_q <= grant_a;
              resp_valid_b_q <= grant_b;
              resp_rdata_q   <= '0;
              resp_err_q     <= 1'b1;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (we_q && !word_store) begin
            merge_q <= mem_rdata;
            state_q <= StWrite;
          end else begin
            state_q        <= StResp;
            resp_valid_a_q <= !sel_b_q;
            resp_valid_b_q <= sel_b_q;
            resp_rdata_q   <= we_q ? '0 : load_val;
            resp_err_q     <= 1'b0;
          end
        end
        StWrite: begin
          state_q        <= StResp;
          resp_valid_a_q <= !sel_b_q;
          resp_valid_b_q <= sel_b_q;
          resp_rdata_q   <= '0;
          resp_err_q     <= 1'b0;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
